// File: rtl/xbus_pkg.sv
// Shared definitions for the Xbus initiator, its responder models and benches.
// Holds the FSM state encoding, default bus widths and the disk-controller
// register addresses that sit at the top of the Xbus I/O page.
package xbus_pkg;

    // FSM state encoding, shared with responder models so traces line up
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam int DEF_ADDR_W = 22;
    localparam int DEF_DATA_W = 32;

    // Disk-controller register block (word addresses, true polarity)
    localparam logic [21:0] DK_REG_CSR = 22'o17377774;
    localparam logic [21:0] DK_REG_WC  = 22'o17377775;
    localparam logic [21:0] DK_REG_BA  = 22'o17377776;
    localparam logic [21:0] DK_REG_DA  = 22'o17377777;

endpackage

// File: rtl/xbus_timeout.sv
// Request watchdog: counts cycles while enabled and flags the last allowed one.
// Ports: mclk/reset (sync, active high), clear (restart at 0), en (count this
// cycle), expired (count has reached TIMEOUT-1; counter holds there).
module xbus_timeout #(
    parameter int TIMEOUT = 256
) (
    input  logic mclk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge mclk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/xbus_initiator.sv
// Xbus initiator: runs one read/write request/acknowledge handshake per start.
// Ports: start/wr/addr/wdata command in; busy/done/rdata/nxm/parerr status out;
// rq_n/adr_n/wrcyc/adrpar_n/bus_out/bus_oe drive the bus, ack_n/bus_in/
// mempar_in come back from the responder. ack_n needs a board pull-up.
// Optional macro XBUS_PARITY_EN enables address parity out and read-data
// parity checking; without it adrpar_n is tied 1 and parerr tied 0.
module xbus_initiator
    import xbus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 256
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              start,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              nxm,
    output logic              parerr,
    output logic              rq_n,
    output logic [ADDR_W-1:0] adr_n,
    output logic              wrcyc,
    output logic              adrpar_n,
    input  logic              ack_n,
    input  logic              mempar_in,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe
);

    logic [1:0] state;
    logic       tmo_expired;

    // Counter restarts in IDLE so each request gets the full window.
    xbus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .mclk    (mclk),
        .reset   (reset),
        .clear   (state == ST_IDLE),
        .en      (state == ST_REQ),
        .expired (tmo_expired)
    );

    assign busy = (state != ST_IDLE);

    // wrcyc doubles as the latched read/write flag for the whole request.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            rdata   <= '0;
            nxm     <= 1'b0;
            rq_n    <= 1'b1;
            adr_n   <= '1;
            wrcyc   <= 1'b0;
            bus_out <= '0;
            bus_oe  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_REQ;
                        nxm     <= 1'b0;
                        rq_n    <= 1'b0;
                        adr_n   <= ~addr;
                        wrcyc   <= wr;
                        bus_oe  <= wr;
                        bus_out <= wdata;
                    end
                end
                ST_REQ: begin
                    if (!ack_n || tmo_expired) begin
                        // Ack wins over a simultaneous expiry.
                        if (!ack_n) begin
                            if (!wrcyc) begin
                                rdata <= bus_in;
                            end
                            state <= ST_RELEASE;
                        end else begin
                            nxm   <= 1'b1;
                            state <= ST_IDLE;
                        end
                        done    <= 1'b1;
                        rq_n    <= 1'b1;
                        adr_n   <= '1;
                        wrcyc   <= 1'b0;
                        bus_oe  <= 1'b0;
                        bus_out <= '0;
                    end
                end
                ST_RELEASE: begin
                    // Responder must drop ack before the next request.
                    if (ack_n) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef XBUS_PARITY_EN
    always_ff @(posedge mclk) begin
        if (reset) begin
            adrpar_n <= 1'b1;
            parerr   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        adrpar_n <= ~(^addr);
                        parerr   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (!ack_n || tmo_expired) begin
                        adrpar_n <= 1'b1;
                    end
                    if (!ack_n && !wrcyc) begin
                        parerr <= (mempar_in != ^bus_in);
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign adrpar_n = 1'b1;
    assign parerr   = 1'b0;
    logic unused_parity;
    assign unused_parity = mempar_in;
`endif

endmodule

// File: tb/tb_xbus_initiator.sv
// Directed bench for xbus_initiator with TIMEOUT=16. Inputs change and outputs
// are sampled on the falling edge; a responder is emulated by driving ack_n.
module tb_xbus_initiator;
    import xbus_pkg::*;

    localparam int AW = 22;
    localparam int DW = 32;
`ifdef XBUS_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    logic          mclk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          busy, done, nxm, parerr, rq_n, wrcyc, adrpar_n, bus_oe;
    logic [DW-1:0] rdata, bus_out;
    logic [AW-1:0] adr_n;
    logic          ack_n = 1'b1;
    logic          mempar_in = 1'b0;
    logic [DW-1:0] bus_in = '0;

    int n_cmp = 0;
    int n_err = 0;
    int rq_falls = 0;
    logic rq_prev = 1'b1;

    always #5 mclk = ~mclk;

    xbus_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .mclk(mclk), .reset(reset), .start(start), .wr(wr), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .nxm(nxm),
        .parerr(parerr), .rq_n(rq_n), .adr_n(adr_n), .wrcyc(wrcyc),
        .adrpar_n(adrpar_n), .ack_n(ack_n), .mempar_in(mempar_in),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe)
    );

    // Counts bus requests issued (falling edges of rq_n).
    always @(negedge mclk) begin
        if (rq_prev && !rq_n) rq_falls++;
        rq_prev = rq_n;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Issue one command; ack is sampled at the ack_at-th posedge after start
    // was accepted (0 = never). Returns the negedge index where done was seen,
    // whether bus drive held steady through REQ, and adrpar_n of the first REQ cycle.
    task automatic xact(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int ack_at, input logic [DW-1:0] rd, input logic par,
                        input int start_at, output int done_cyc, output logic hold_ok,
                        output logic apar);
        start = 1'b1; wr = w; addr = a; wdata = d;
        @(negedge mclk);
        start = 1'b0; addr = ~a; wdata = ~d; wr = ~w;
        apar = adrpar_n;
        done_cyc = -1;
        hold_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (rq_n == 1'b0) begin
                if (adr_n !== ~a || wrcyc !== w || bus_oe !== w || busy !== 1'b1 ||
                    (w && bus_out !== d)) hold_ok = 1'b0;
            end else begin
                hold_ok = 1'b0;
            end
            start = (k == start_at);
            if (k == ack_at) begin
                ack_n = 1'b0; bus_in = rd; mempar_in = par;
            end
            @(negedge mclk);
            start = 1'b0;
            if (done) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    // Keep ack low for 'hold' cycles (pulsing start once), then release it.
    task automatic release_ack(input int hold, input string tag);
        logic stayed = 1'b1;
        for (int i = 0; i < hold; i++) begin
            start = (i == 2);
            @(negedge mclk);
            if (busy !== 1'b1 || rq_n !== 1'b1 || done !== 1'b0) stayed = 1'b0;
        end
        start = 1'b0;
        chk({tag, "_release_hold"}, stayed, 1'b1);
        ack_n = 1'b1;
        @(negedge mclk);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    int   dc;
    logic hok, ap;
    int   falls0;

    initial begin
        repeat (2) @(negedge mclk);
        reset = 1'b0;
        @(negedge mclk);
        chk("rst_rq_n", rq_n, 1'b1);
        chk("rst_adr_n", adr_n, {AW{1'b1}});
        chk("rst_oe_out", {bus_oe, wrcyc, bus_out}, '0);
        chk("rst_status", {busy, done, nxm, parerr, adrpar_n}, 5'b00001);
        chk("rst_rdata", rdata, '0);

        // Read CSR, ack at 3rd REQ edge, bus_in=1
        xact(1'b0, DK_REG_CSR, 32'h0, 3, 32'd1, 1'b1, 0, dc, hok, ap);
        chk("rd_done_cyc", dc, 3);
        chk("rd_rdata", rdata, 32'd1);
        chk("rd_nxm", nxm, 1'b0);
        chk("rd_parerr", parerr, 1'b0);
        chk("rd_rq_released", rq_n, 1'b1);
        chk("rd_hold", hok, 1'b1);
        chk("rd_adrpar", ap, PAR_ON ? 1'b0 : 1'b1);
        ack_n = 1'b1;
        @(negedge mclk);
        chk("rd_done_pulse", done, 1'b0);
        chk("rd_idle", busy, 1'b0);

        // Write WC with 32'o1234, ack at 2nd REQ edge
        xact(1'b1, DK_REG_WC, 32'o1234, 2, 32'hFFFF_FFFF, 1'b0, 0, dc, hok, ap);
        chk("wr_done_cyc", dc, 2);
        chk("wr_hold", hok, 1'b1);
        chk("wr_oe_off", {bus_oe, wrcyc}, 2'b00);
        chk("wr_rdata_kept", rdata, 32'd1);
        ack_n = 1'b1;
        @(negedge mclk);
        chk("wr_idle", busy, 1'b0);

        // No ack: timeout after 16 REQ cycles
        bus_in = 32'hDEAD_BEEF;
        xact(1'b0, DK_REG_BA, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 0, dc, hok, ap);
        chk("to_done_cyc", dc, 16);
        chk("to_nxm", nxm, 1'b1);
        chk("to_rq_n", {rq_n, bus_oe}, 2'b10);
        chk("to_rdata_kept", rdata, 32'd1);
        chk("to_busy", busy, 1'b0);
        @(negedge mclk);
        chk("to_done_pulse", done, 1'b0);
        chk("to_nxm_sticky", nxm, 1'b1);

        // Start ignored during REQ and RELEASE; ack held 5 extra cycles
        falls0 = rq_falls;
        xact(1'b0, DK_REG_DA, 32'h0, 2, 32'h5A5A_0F0F, 1'b0, 1, dc, hok, ap);
        chk("ign_done_cyc", dc, 2);
        chk("ign_nxm_cleared", nxm, 1'b0);
        chk("ign_rdata", rdata, 32'h5A5A_0F0F);
        release_ack(5, "ign");
        @(negedge mclk);
        chk("ign_one_request", rq_falls - falls0, 1);

        // Reset during 2nd REQ cycle of a write
        start = 1'b1; wr = 1'b1; addr = DK_REG_CSR; wdata = 32'h1357;
        @(negedge mclk);
        start = 1'b0;
        @(negedge mclk);
        chk("mr_pre_oe", bus_oe, 1'b1);
        reset = 1'b1;
        @(negedge mclk);
        chk("mr_bus", {rq_n, bus_oe, busy, done}, 4'b1000);
        reset = 1'b0;
        @(negedge mclk);
        chk("mr_no_done", {done, busy, rq_n}, 3'b001);

        // Read of address 0 returning 32'o0101 with wrong parity (even data, par=1)
        xact(1'b0, 22'o0, 32'h0, 1, 32'o0101, 1'b1, 0, dc, hok, ap);
        chk("p1_done_cyc", dc, 1);
        chk("p1_rdata", rdata, 32'o0101);
        chk("p1_parerr", parerr, PAR_ON);
        chk("p1_adrpar", ap, 1'b1);
        ack_n = 1'b1;
        @(negedge mclk);
        chk("p1_parerr_sticky", parerr, PAR_ON);

        // Same read with correct parity
        xact(1'b0, 22'o0, 32'h0, 1, 32'o0101, 1'b0, 0, dc, hok, ap);
        chk("p0_parerr", parerr, 1'b0);
        chk("p0_rdata", rdata, 32'o0101);
        ack_n = 1'b1;
        @(negedge mclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xbus_initiator.md
Name: xbus_initiator

Overview:
- CPU-side master for the Xbus request/acknowledge protocol; the counterpart of the bus-interface responder.
- Accepts one read or write command at a time from the memory-control logic.
- Drives active-low address, rq_n and wrcyc, plus write data on the shared bus.
- Waits for the responder's ack_n, captures read data, then releases the bus.
- Times out to a non-existent-memory (NXM) error if no ack arrives.

Parameters:
ADDR_W, 22, address width (matches adr_n)
DATA_W, 32, data bus width
TIMEOUT, 256, cycles in REQ without ack before NXM abort (min 4)

Ports:
mclk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  command strobe, sampled only in IDLE
wr  in  1  1 = write cycle, 0 = read
addr  in  ADDR_W  true-polarity word address
wdata  in  DATA_W  write data
busy  out  1  command in progress (state != IDLE)
done  out  1  one-cycle pulse at command completion (ack or timeout)
rdata  out  DATA_W  captured read data, held until next read completes
nxm  out  1  last command timed out; cleared on next accepted start
parerr  out  1  read-data parity error on last read (see feature)
rq_n  out  1  bus request, active low
adr_n  out  ADDR_W  inverted latched address
wrcyc  out  1  write-cycle qualifier
adrpar_n  out  1  address parity, active low
ack_n  in  1  responder acknowledge, active low (undriven treated as 1)
mempar_in  in  1  data parity returned by responder
bus_in  in  DATA_W  bus value, for reads
bus_out  out  DATA_W  bus drive value
bus_oe  out  1  enable for bus_out (top level builds tristate)

Behaviour:
- Reset values:
  - rq_n=1, adr_n=all ones, wrcyc=0, bus_oe=0, bus_out=0
  - busy=0, done=0, rdata=0, nxm=0, parerr=0, adrpar_n=1
  - state=IDLE, timeout counter=0
- States: IDLE, REQ, RELEASE.
- IDLE:
  - On start=1, latch addr/wdata/wr, clear nxm and parerr, go to REQ.
  - Next cycle: rq_n=0, adr_n=~addr, wrcyc=wr, bus_oe=wr, bus_out=wdata. All outputs registered; rq_n falls one cycle after start.
- REQ:
  - ack_n is sampled each posedge; counter increments each REQ cycle.
  - On ack_n=0:
    - For a read, rdata<=bus_in.
    - done pulses the following cycle; rq_n=1, bus_oe=0, wrcyc=0.
    - Go to RELEASE.
    - Latency from rq_n low to done is ack delay + 1 cycle.
  - On counter reaching TIMEOUT-1 with ack_n=1:
    - nxm<=1, done pulse, rq_n=1, bus_oe=0, go IDLE.
    - rdata is unchanged.
- RELEASE:
  - Wait for ack_n=1, then go IDLE.
  - If ack_n stays 0, remain in RELEASE indefinitely; busy stays 1 and no new rq_n is issued.
- start while busy=1 is ignored; no queuing.
- ack_n=0 already present on entry to REQ is treated as a valid ack on the first REQ cycle.
- Address and write data are held stable for the whole REQ state regardless of input changes.
- Reset mid-operation: next posedge forces the reset values, with rq_n=1 and bus_oe=0 immediately; no done pulse.
- done and nxm are never asserted together with a captured rdata update for a timed-out read.

Optional Feature:
- Macro: XBUS_PARITY_EN.
- Defined:
  - adrpar_n = ~(^addr_latched), valid while rq_n=0, 1 otherwise.
  - On read ack, parerr<=(mempar_in != ^bus_in).
  - parerr is sticky until next accepted start.
- Undefined:
  - adrpar_n is constant 1, parerr is constant 0, mempar_in is ignored.

Decomposition:
- Shared package xbus_pkg:
  - state encoding (IDLE=2'd0, REQ=2'd1, RELEASE=2'd2)
  - default ADDR_W/DATA_W
  - disk-controller register addresses (22'o17377774..22'o17377777), shared with responder models and benches
- Sub-module xbus_timeout: loadable counter with clear/enable/expired.

Test Plan:
- Read 22'o17377774; responder acks 3 cycles after rq_n low with bus_in=1 -> rdata=1, done one cycle after ack, nxm=0, adr_n=~22'o17377774 during REQ.
- Write 22'o17377775 with wdata=32'o1234; ack after 2 cycles -> bus_oe=1 and bus_out=32'o1234 for all REQ cycles, wrcyc=1, done pulse, then bus_oe=0.
- TIMEOUT=16, no ack -> done and nxm=1 exactly 16 REQ cycles after rq_n low, rq_n=1, rdata unchanged, next start clears nxm.
- start pulsed during REQ and during RELEASE with ack_n held low 5 extra cycles -> ignored, busy stays 1 until ack_n rises, only one rq_n assertion.
- reset asserted on 2nd REQ cycle -> rq_n=1, bus_oe=0, busy=0, no done; a later read of 22'o00000000 returning 32'o0101 completes normally.
- With XBUS_PARITY_EN: read returns 32'o0101 with wrong mempar_in -> parerr=1; correct parity -> parerr=0.
